// File: rtl/mux_sel_sequencer_pkg.sv
// rtl/mux_sel_sequencer_pkg.sv - shared widths, state encoding and index helpers for the mux sequencer
package mux_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 2**SEL_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // First select index of a word: 0 when counting up, top index when counting down
    function automatic int start_idx(input int sel_w, input bit msb_first);
        return msb_first ? (2**sel_w) - 1 : 0;
    endfunction

    // Final select index of a word: the opposite end of the range from start_idx
    function automatic int end_idx(input int sel_w, input bit msb_first);
        return msb_first ? 0 : (2**sel_w) - 1;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// rtl/mux_sel_sequencer_if.sv - source word, mux loop, serial stream and capture signals
interface mux_sel_sequencer_if #(
    parameter int SEL_W = mux_pkg::SEL_W
);

    localparam int DATA_W = 2**SEL_W;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] mux_data;
    logic [SEL_W-1:0]  mux_s;
    logic              mux_y;
    logic              ser_bit;
    logic              ser_valid;
    logic              ser_last;
    logic              ser_ready;
    logic [DATA_W-1:0] cap_word;
    logic              done;
    logic              err;

    // Sequencer side: owns the mux lines, the serial stream and the capture results
    modport master (
        input  in_valid, in_data, mux_y, ser_ready,
        output in_ready, mux_data, mux_s, ser_bit, ser_valid, ser_last, cap_word, done, err
    );

    // Environment side: supplies words, closes the mux loop and consumes the stream
    modport slave (
        output in_valid, in_data, mux_y, ser_ready,
        input  in_ready, mux_data, mux_s, ser_bit, ser_valid, ser_last, cap_word, done, err
    );

endinterface

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - drives an 8:1 mux through every select, streams and checks its output
module mux_sel_sequencer
    import mux_pkg::*;
#(
    parameter int SEL_W     = mux_pkg::SEL_W,
    parameter int MSB_FIRST = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_sel_sequencer_if.master bus
);

    localparam int DATA_W = 2**SEL_W;
    localparam logic [SEL_W-1:0] START_IDX = SEL_W'(start_idx(SEL_W, MSB_FIRST != 0));
    localparam logic [SEL_W-1:0] END_IDX   = SEL_W'(end_idx(SEL_W, MSB_FIRST != 0));

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mux_data;
    logic [DATA_W-1:0] r_cap_word;
    logic [SEL_W-1:0]  r_mux_s;
    logic              r_err;

    logic              w_in_ready;
    logic              w_ser_valid;
    logic              w_done;
    logic              w_in_fire;
    logic              w_ser_fire;
    logic              w_at_end;
    logic [SEL_W-1:0]  w_mux_s_step;

    assign w_at_end     = (r_mux_s == END_IDX);
    assign w_mux_s_step = (MSB_FIRST != 0) ? (r_mux_s - SEL_W'(1)) : (r_mux_s + SEL_W'(1));

    // State register; reset abandons any word in flight without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake strobes, all derived from the current state
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_ser_valid = 1'b0;
        w_done      = 1'b0;
        w_in_fire   = 1'b0;
        w_ser_fire  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_in_fire  = bus.in_valid;
                if (w_in_fire) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_ser_valid = 1'b1;
                w_ser_fire  = bus.ser_ready;
                if (w_ser_fire && w_at_end) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Word latch, select stepping, bit capture and sticky mismatch flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mux_data <= '0;
            r_mux_s    <= START_IDX;
            r_cap_word <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_mux_data <= bus.in_data;
                r_mux_s    <= START_IDX;
                r_cap_word <= '0;
            end
            if (w_ser_fire) begin
                r_cap_word[r_mux_s] <= bus.mux_y;
                if (bus.mux_y != r_mux_data[r_mux_s]) begin
                    r_err <= 1'b1;
                end
                // Stepping past the end index is suppressed so the select never wraps
                if (!w_at_end) begin
                    r_mux_s <= w_mux_s_step;
                end
            end
            if (w_done) begin
                r_mux_s <= START_IDX;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mux_data  = r_mux_data;
    assign bus.mux_s     = r_mux_s;
    assign bus.ser_bit   = bus.mux_y;
    assign bus.ser_valid = w_ser_valid;
    assign bus.ser_last  = w_ser_valid & w_at_end;
    assign bus.cap_word  = r_cap_word;
    assign bus.done      = w_done;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - scoreboard bench for both select orders with a faultable mux model
module tb_mux_sel_sequencer;
    import mux_pkg::*;

    typedef struct packed {
        logic [2:0] sel;
        logic       b;
        logic       last;
        logic [7:0] word;
    } bit_exp_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       ser_ready = 1'b0;
    logic       fault_en  = 1'b0;
    int         rdy_mode  = 0;
    int         rdy_phase = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    mux_sel_sequencer_if #(.SEL_W(3)) bus_l ();
    mux_sel_sequencer_if #(.SEL_W(3)) bus_m ();

    // 8:1 mux models closing the loop; fault_en forces y=1 at select 3
    assign bus_l.mux_y = (fault_en && bus_l.mux_s == 3'd3) ? 1'b1 : bus_l.mux_data[bus_l.mux_s];
    assign bus_m.mux_y = (fault_en && bus_m.mux_s == 3'd3) ? 1'b1 : bus_m.mux_data[bus_m.mux_s];

    assign bus_l.in_valid  = in_valid;
    assign bus_l.in_data   = in_data;
    assign bus_l.ser_ready = ser_ready;
    assign bus_m.in_valid  = in_valid;
    assign bus_m.in_data   = in_data;
    assign bus_m.ser_ready = ser_ready;

    mux_sel_sequencer #(.SEL_W(3), .MSB_FIRST(0)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l.master)
    );

    mux_sel_sequencer #(.SEL_W(3), .MSB_FIRST(1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic       ob_in_ready [2];
    logic       ob_ser_valid[2];
    logic       ob_ser_last [2];
    logic       ob_ser_bit  [2];
    logic       ob_done     [2];
    logic       ob_err      [2];
    logic [2:0] ob_mux_s    [2];
    logic [7:0] ob_mux_data [2];
    logic [7:0] ob_cap      [2];

    assign ob_in_ready[0]  = bus_l.in_ready;   assign ob_in_ready[1]  = bus_m.in_ready;
    assign ob_ser_valid[0] = bus_l.ser_valid;  assign ob_ser_valid[1] = bus_m.ser_valid;
    assign ob_ser_last[0]  = bus_l.ser_last;   assign ob_ser_last[1]  = bus_m.ser_last;
    assign ob_ser_bit[0]   = bus_l.ser_bit;    assign ob_ser_bit[1]   = bus_m.ser_bit;
    assign ob_done[0]      = bus_l.done;       assign ob_done[1]      = bus_m.done;
    assign ob_err[0]       = bus_l.err;        assign ob_err[1]       = bus_m.err;
    assign ob_mux_s[0]     = bus_l.mux_s;      assign ob_mux_s[1]     = bus_m.mux_s;
    assign ob_mux_data[0]  = bus_l.mux_data;   assign ob_mux_data[1]  = bus_m.mux_data;
    assign ob_cap[0]       = bus_l.cap_word;   assign ob_cap[1]       = bus_m.cap_word;

    // Scoreboard: per-instance expected bits and captured words, plus model err
    bit_exp_t   q_bit [2][$];
    logic [7:0] q_cap [2][$];
    logic       err_m   [2] = '{1'b0, 1'b0};
    int         hs_cnt  [2] = '{0, 0};
    int         done_cnt[2] = '{0, 0};
    int         n_acc   [2] = '{0, 0};
    int         acc_cyc [$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instance 0 visits selects 0..7, instance 1 visits 7..0
    function automatic void push_word(input logic [7:0] w);
        bit_exp_t   e;
        logic [7:0] cap;
        int         s;
        for (int k = 0; k < 2; k++) begin
            cap = 8'h00;
            for (int i = 0; i < 8; i++) begin
                s      = (k == 0) ? i : 7 - i;
                e.sel  = 3'(s);
                e.b    = (fault_en && s == 3) ? 1'b1 : w[s];
                e.last = (i == 7);
                e.word = w;
                cap[s] = e.b;
                q_bit[k].push_back(e);
            end
            q_cap[k].push_back(cap);
            n_acc[k]++;
        end
        acc_cyc.push_back(cyc);
    endfunction

    // Monitor: sampled on the falling edge, between input updates and the active edge
    always @(negedge clk) begin : monitor
        bit_exp_t e;
        logic     exp_rdy;
        logic     exp_done;
        logic     rdy0;
        rdy0 = 1'b0;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                exp_rdy  = (q_bit[k].size() == 0) && (q_cap[k].size() == 0);
                exp_done = (q_bit[k].size() == 0) && (q_cap[k].size() != 0);
                if (k == 0) rdy0 = exp_rdy;
                cmp("in_ready",  32'(ob_in_ready[k]),  32'(exp_rdy));
                cmp("ser_valid", 32'(ob_ser_valid[k]), 32'(q_bit[k].size() != 0));
                cmp("done",      32'(ob_done[k]),      32'(exp_done));
                cmp("err",       32'(ob_err[k]),       32'(err_m[k]));
                if (q_bit[k].size() != 0) begin
                    e = q_bit[k][0];
                    cmp("mux_s",    32'(ob_mux_s[k]),    32'(e.sel));
                    cmp("ser_bit",  32'(ob_ser_bit[k]),  32'(e.b));
                    cmp("ser_last", 32'(ob_ser_last[k]), 32'(e.last));
                    cmp("mux_data", 32'(ob_mux_data[k]), 32'(e.word));
                    if (ser_ready) begin
                        void'(q_bit[k].pop_front());
                        if (e.b != e.word[e.sel]) err_m[k] = 1'b1;
                        hs_cnt[k]++;
                    end
                end else if (q_cap[k].size() != 0) begin
                    cmp("cap_word", 32'(ob_cap[k]), 32'(q_cap[k].pop_front()));
                    done_cnt[k]++;
                end
            end
            if (in_valid && rdy0) push_word(in_data);
        end
    end

    // Downstream ready: 0 = always, 1 = repeating 1,0,0, otherwise random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: ser_ready = 1'b1;
                1: begin
                    ser_ready = (rdy_phase % 3 == 0);
                    rdy_phase++;
                end
                default: ser_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_word(input logic [7:0] w, input bit keep);
        int n0 = acc_cyc.size();
        bit ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(posedge clk);
            ok = (acc_cyc.size() > n0);
        end
        #1;
        if (!keep) in_valid = 1'b0;
        cmp("word_accepted", 32'(ok), 32'(1));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            ok = (q_bit[0].size() + q_bit[1].size() + q_cap[0].size() + q_cap[1].size()) == 0;
        end
        cmp("drained", 32'(ok), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        for (int k = 0; k < 2; k++) begin
            cmp("rst_in_ready",  32'(ob_in_ready[k]),  32'(1));
            cmp("rst_ser_valid", 32'(ob_ser_valid[k]), 32'(0));
            cmp("rst_ser_last",  32'(ob_ser_last[k]),  32'(0));
            cmp("rst_done",      32'(ob_done[k]),      32'(0));
            cmp("rst_err",       32'(ob_err[k]),       32'(0));
            cmp("rst_cap_word",  32'(ob_cap[k]),       32'(0));
            cmp("rst_mux_data",  32'(ob_mux_data[k]),  32'(0));
            cmp("rst_mux_s",     32'(ob_mux_s[k]),     32'((k == 0) ? 0 : 7));
        end
    endtask

    task automatic flush_model();
        for (int k = 0; k < 2; k++) begin
            n_acc[k] -= q_cap[k].size();
            q_bit[k].delete();
            q_cap[k].delete();
            err_m[k] = 1'b0;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int         base;
        int         n0;
        logic [7:0] w;

        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;

        // Single word, full throughput; both select orders run side by side
        rdy_mode = 0;
        send_word(8'hB6, 1'b0);
        wait_idle();

        // Stalled stream: selects and bits must hold while ready is low
        rdy_mode  = 1;
        rdy_phase = 0;
        send_word(8'h5A, 1'b0);
        wait_idle();

        // Faulty mux at select 3, then a clean word; err must stay set
        rdy_mode = 0;
        fault_en = 1'b1;
        send_word(8'h00, 1'b0);
        wait_idle();
        fault_en = 1'b0;
        send_word(8'hFF, 1'b0);
        wait_idle();
        cmp("err_sticky_lsb", 32'(ob_err[0]), 32'(1));
        cmp("err_sticky_msb", 32'(ob_err[1]), 32'(1));

        // Reset after the fourth bit of a word abandons it without a done pulse
        base = hs_cnt[0];
        send_word(8'hC3, 1'b0);
        for (int t = 0; t < 100 && hs_cnt[0] < base + 4; t++) @(posedge clk);
        cmp("fourth_bit_seen", 32'(hs_cnt[0] - base), 32'(4));
        #1;
        rst_n = 1'b0;
        #1;
        check_reset();
        flush_model();
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
        send_word(8'h3C, 1'b0);
        wait_idle();

        // Back-to-back words with valid held high
        n0 = acc_cyc.size();
        send_word(8'h01, 1'b1);
        send_word(8'h80, 1'b0);
        if (acc_cyc.size() >= n0 + 2) begin
            cmp("b2b_gap", 32'(acc_cyc[n0 + 1] - acc_cyc[n0]), 32'(10));
        end else begin
            cmp("b2b_accepts", 32'(acc_cyc.size() - n0), 32'(2));
        end
        wait_idle();

        // Random words under random downstream backpressure and idle gaps
        rdy_mode = 2;
        for (int i = 0; i < 24; i++) begin
            w = 8'($urandom);
            send_word(w, 1'b0);
            if ($urandom_range(0, 2) == 0) wait_idle();
            else repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        wait_idle();

        for (int k = 0; k < 2; k++) begin
            cmp("done_count", 32'(done_cnt[k]), 32'(n_acc[k]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
Upstream driver and capture stage for the team's 8:1 selector mux.
- Accepts an 8-bit word over a valid/ready handshake and presents it on the mux data lines.
- Steps the 3-bit select through every index and emits the selected mux output as a serial bit stream with valid/ready flow control.
- Reassembles the captured bits into a word, compares them against the source word and flags any mismatch.

Parameters:
- SEL_W, 3: selector width; data width is 2**SEL_W.
- MSB_FIRST, 0: 0 = select counts 0 up to 7; 1 = select counts 7 down to 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  8  source word; bit i drives mux input i (a=bit0 … h=bit7).
- mux_data  out  8  registered copy of the accepted word, wired to mux inputs a..h.
- mux_s  out  3  mux select.
- mux_y  in  1  mux output; combinational from mux_data/mux_s.
- ser_bit  out  1  serial data (= mux_y).
- ser_valid  out  1  ser_bit valid.
- ser_last  out  1  current bit is the final index.
- ser_ready  in  1  downstream accepts ser_bit.
- cap_word  out  8  reassembled captured word, valid when done=1.
- done  out  1  one-cycle pulse at the end of a word.
- err  out  1  sticky mismatch flag.

Behaviour:
- Reset (async assert, sync release): state=IDLE, mux_data=0, mux_s=0 (7 if MSB_FIRST), cap_word=0, ser_valid=0, ser_last=0, done=0, err=0. in_ready=1 once in IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid at an edge: latch in_data into mux_data, load mux_s with the start index, clear cap_word, go to SHIFT.
- SHIFT:
  - in_ready=0, ser_valid=1, ser_bit=mux_y (combinational passthrough).
  - ser_last=1 when mux_s equals the end index (7, or 0 if MSB_FIRST).
  - On ser_valid&&ser_ready at an edge:
    - cap_word[mux_s] <= mux_y.
    - If mux_y != mux_data[mux_s], err <= 1.
    - If last: go to DONE; otherwise step mux_s by ±1.
  - Without ser_ready: hold mux_s, mux_data and cap_word. ser_bit tracks mux_y and must stay stable.
- DONE:
  - Lasts exactly one cycle: done=1, in_ready=0, ser_valid=0.
  - Next state is IDLE; mux_s reloads the start index.
- mux_data is constant from accept until return to IDLE. It changes only on accept.
- Latency with ser_ready held at 1, word accepted at edge T:
  - First bit valid in the cycle after T.
  - Eighth bit accepted at edge T+8.
  - done high in the cycle after T+8.
  - in_ready high again 2 cycles after T+8.
- Throughput: one word per 10 cycles maximum.
- Select wrap: mux_s never wraps within a word. The step past the end index is suppressed.
- err: sticky and never auto-cleared; only rst_n clears it. It may be set on any bit of any word.
- in_valid is ignored outside IDLE. A word presented during SHIFT or DONE waits under valid/ready rules.
- rst_n asserted mid-SHIFT: the word is abandoned, all outputs return to reset values immediately, and no done pulse is produced.
- X on mux_y: no X-suppression, the bit is captured as-is. The bench treats any X as a failure.

Decomposition:
- Shared package mux_pkg holds: SEL_W, DATA_W = 2**SEL_W, the state enum {IDLE, SHIFT, DONE}, and the start/end index constants derived from MSB_FIRST.
- No sub-module in the sequencer itself. The existing 8:1 mux is instantiated only in the testbench, closing the mux_data/mux_s → mux_y loop.

Test Plan:
1. Reset, then in_data=8'b1011_0110 with ser_ready=1 and the real mux in the loop:
   - ser_bit sequence 0,1,1,0,1,1,0,1.
   - ser_last on the 8th bit.
   - done one cycle later, cap_word=8'hB6, err=0.
2. MSB_FIRST=1, in_data=8'hB6:
   - mux_s sequence 7..0.
   - ser_bit sequence 1,0,1,1,0,1,1,0.
   - cap_word=8'hB6.
3. ser_ready toggled 1,0,0,1,… during in_data=8'h5A:
   - mux_s and ser_bit hold during stalls.
   - cap_word=8'h5A after 8 handshakes; done exactly once.
4. Faulty mux model forces y=1 at s=3 with in_data=8'h00:
   - err rises on the edge that accepts index 3.
   - cap_word=8'h08.
   - err stays 1 through the next correct word (8'hFF).
5. Assert rst_n low after the 4th bit of 8'hC3:
   - Outputs return to reset immediately; no done pulse.
   - After release, 8'h3C completes with cap_word=8'h3C.
6. Back-to-back words 8'h01 then 8'h80 with in_valid held high:
   - Second accepted exactly 10 cycles after the first.
   - Two done pulses; cap_word 8'h01 then 8'h80.
